gpr_file_mp: RTL

//  Parametrised multi-port general-purpose register file for the core: NRD combinational read ports,
//  two prioritised write ports (writeback + late/long-latency), optional write-to-read bypass,
//  a per-register busy scoreboard for outstanding long-latency ops, and a req/ack debug-bus port

---
 rtl/gpr_file_mp_pkg.sv | 14 +
 rtl/gpr_bus_port.sv | 49 ++++
 rtl/gpr_file_mp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gpr_file_mp_pkg.sv
// Shared definitions for the multi-port GPR file: debug-port FSM encodings
// and the register-address validity rule.
package gpr_file_mp_pkg;

    localparam logic [1:0] GPR_FSM_IDLE = 2'd0;
    localparam logic [1:0] GPR_FSM_WAIT = 2'd1;
    localparam logic [1:0] GPR_FSM_ACK  = 2'd2;

    // x0 and anything beyond the implemented register count behave as hardwired zero.
    function automatic logic gpr_addr_ok(input logic [4:0] a, input int unsigned nreg);
        return (a != 5'd0) && (32'(a) < nreg);
    endfunction

endpackage

// File: rtl/gpr_bus_port.sv
// Debug-bus request/ack sequencer for the GPR file. Issues a write request only
// in cycles free of core writes, and an rdata latch enable for reads.
module gpr_bus_port
    import gpr_file_mp_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [4:0]      i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_core_wr,
    output logic            o_ack,
    output logic            o_wr_en,
    output logic [4:0]      o_wr_addr,
    output logic [XLEN-1:0] o_wr_data,
    output logic            o_rd_latch
);

    logic [1:0] r_state;
    logic       w_accepting;

    assign w_accepting = (r_state == GPR_FSM_IDLE) || (r_state == GPR_FSM_WAIT);
    assign o_wr_en     = w_accepting & i_req & i_we & ~i_core_wr;
    assign o_wr_addr   = i_addr;
    assign o_wr_data   = i_wdata;
    assign o_rd_latch  = (r_state == GPR_FSM_IDLE) & i_req & ~i_we;
    assign o_ack       = (r_state == GPR_FSM_ACK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= GPR_FSM_IDLE;
        end else begin
            case (r_state)
                GPR_FSM_IDLE: begin
                    if (i_req) begin
                        if (!i_we || !i_core_wr) r_state <= GPR_FSM_ACK;
                        else                     r_state <= GPR_FSM_WAIT;
                    end
                end
                GPR_FSM_WAIT: if (!i_core_wr) r_state <= GPR_FSM_ACK;
                default:      r_state <= GPR_FSM_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: NRD combinational read ports, prioritised writeback/late
// write ports with optional bypass, busy scoreboard and an arbitrated debug port.
module gpr_file_mp
    import gpr_file_mp_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*5-1:0]  raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]    rbusy_o,
    input  logic              we0_i,
    input  logic [4:0]        waddr0_i,
    input  logic [XLEN-1:0]   wdata0_i,
    input  logic              we1_i,
    input  logic [4:0]        waddr1_i,
    input  logic [XLEN-1:0]   wdata1_i,
    input  logic              bsy_set_i,
    input  logic [4:0]        bsy_addr_i,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [4:0]        bus_addr_i,
    input  logic [XLEN-1:0]   bus_wdata_i,
    output logic              bus_ack_o,
    output logic [XLEN-1:0]   bus_rdata_o
);

    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0] r_regs [32];
    logic [31:0]     r_busy;
    logic [XLEN-1:0] r_bus_rdata;

    logic            w_core_wr;
    logic            w_wr0_ok;
    logic            w_wr1_ok;
    logic            w_bsy_ok;
    logic            w_bus_wr_en;
    logic            w_bus_wr_ok;
    logic [4:0]      w_bus_waddr;
    logic [XLEN-1:0] w_bus_wdata;
    logic            w_bus_rd_latch;

    assign w_core_wr   = we0_i | we1_i;
    assign w_wr0_ok    = we0_i & gpr_addr_ok(waddr0_i, NREG);
    assign w_wr1_ok    = we1_i & gpr_addr_ok(waddr1_i, NREG);
    assign w_bsy_ok    = bsy_set_i & gpr_addr_ok(bsy_addr_i, NREG);
    assign w_bus_wr_ok = w_bus_wr_en & gpr_addr_ok(w_bus_waddr, NREG);

    gpr_bus_port #(.XLEN(XLEN)) u_bus_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (bus_req_i),
        .i_we       (bus_we_i),
        .i_addr     (bus_addr_i),
        .i_wdata    (bus_wdata_i),
        .i_core_wr  (w_core_wr),
        .o_ack      (bus_ack_o),
        .o_wr_en    (w_bus_wr_en),
        .o_wr_addr  (w_bus_waddr),
        .o_wr_data  (w_bus_wdata),
        .o_rd_latch (w_bus_rd_latch)
    );

    // Array is always 32 deep; unimplemented entries are held at zero and prune away.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 32; i++) begin
            if (!rst_n || i == 0 || i >= NREG)
                r_regs[i] <= '0;
            else if (w_wr0_ok && waddr0_i == 5'(i))
                r_regs[i] <= wdata0_i;
            else if (w_wr1_ok && waddr1_i == 5'(i))
                r_regs[i] <= wdata1_i;
            else if (w_bus_wr_ok && w_bus_waddr == 5'(i))
                r_regs[i] <= w_bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (w_bsy_ok && bsy_addr_i == 5'(i))
                    r_busy[i] <= 1'b1;
                else if (we1_i && waddr1_i == 5'(i))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_bus_rdata <= '0;
        else if (w_bus_rd_latch)
            r_bus_rdata <= gpr_addr_ok(bus_addr_i, NREG) ? r_regs[bus_addr_i] : '0;
    end

    assign bus_rdata_o = r_bus_rdata;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [4:0]      w_ra;
        logic            w_ok;
        logic            w_hit0;
        logic            w_hit1;
        logic [XLEN-1:0] w_rd;

        assign w_ra   = raddr_i[5*k +: 5];
        assign w_ok   = gpr_addr_ok(w_ra, NREG);
        assign w_hit0 = BYP && we0_i && (waddr0_i == w_ra);
        assign w_hit1 = BYP && we1_i && (waddr1_i == w_ra);

        always_comb begin
            w_rd = r_regs[w_ra];
            if (!w_ok)       w_rd = '0;
            else if (w_hit0) w_rd = wdata0_i;
            else if (w_hit1) w_rd = wdata1_i;
        end

        assign rdata_o[XLEN*k +: XLEN] = w_rd;
        assign rbusy_o[k] = w_ok & r_busy[w_ra] & ~w_hit1;
    end

endmodule
